// File: rtl/seg7_display_arbiter.sv
// Shares a multiplexed seven-segment display between n_req requesters:
// round-robin grant with minimum hold, one-frame blanking between owners, hex decode.
module seg7_display_arbiter #(
   parameter int w_digit      = 4,
   parameter int n_req        = 2,
   parameter int digit_period = 50000,
   parameter int hold_ticks   = 1000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [n_req-1:0]           req,
   input  logic [n_req*w_digit*4-1:0] req_value,
   input  logic [n_req*w_digit-1:0]   req_dots,
   output logic [n_req-1:0]           grant,
   output logic [7:0]                 abcdefgh,
   output logic [w_digit-1:0]         digit,
   output logic                       busy
);
   // state | meaning
   // IDLE  | no owner, display dark, waiting for any req
   // OWN   | one requester owns the display, digits scanned
   // BLANK | dark for one full frame before the next owner
   typedef enum logic [1:0] {IDLE, OWN, BLANK} state_t;

   localparam int TW = (digit_period > 1) ? $clog2(digit_period) : 1;
   localparam int IW = (w_digit > 1) ? $clog2(w_digit) : 1;
   localparam int HW = (hold_ticks > 0) ? $clog2(hold_ticks + 1) : 1;
   localparam int BW = $clog2(w_digit + 1);
   localparam int OW = $clog2(n_req);

   state_t                state, state_nxt;
   logic [TW-1:0]         tick_cnt;
   logic                  tick;
   logic [IW-1:0]         scan_idx;
   logic [HW-1:0]         hold_cnt;
   logic [BW-1:0]         blank_cnt;
   logic [OW-1:0]         rr, rr_nxt, owner, owner_nxt, winner;
   logic [n_req-1:0]      grant_nxt;
   logic [2*n_req-1:0]    req_rot;
   logic                  found, owner_req, others_req;
   logic [3:0]            nib_of [n_req][w_digit];
   logic                  dot_of [n_req][w_digit];

   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: hex7 = 7'h7E;  4'h1: hex7 = 7'h30;  4'h2: hex7 = 7'h6D;  4'h3: hex7 = 7'h79;
         4'h4: hex7 = 7'h33;  4'h5: hex7 = 7'h5B;  4'h6: hex7 = 7'h5F;  4'h7: hex7 = 7'h70;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h7B;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h1F;
         4'hC: hex7 = 7'h4E;  4'hD: hex7 = 7'h3D;  4'hE: hex7 = 7'h4F;  default: hex7 = 7'h47;
      endcase
   endfunction

   assign tick       = (tick_cnt == TW'(digit_period - 1));
   assign owner_req  = |(req & grant);
   assign others_req = |(req & ~grant);
   assign busy       = (state != IDLE);
   assign req_rot    = {req, req} >> rr;

   // Rotated request vector: first set bit is the nearest requester at or above rr.
   always_comb begin
      winner = rr;
      found  = 1'b0;
      for (int k = 0; k < n_req; k++) begin
         if (!found && req_rot[k]) begin
            found  = 1'b1;
            winner = OW'((int'(rr) + k) % n_req);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < n_req; i++) begin
         for (int j = 0; j < w_digit; j++) begin
            nib_of[i][j] = req_value[(i*w_digit + j)*4 +: 4];
            dot_of[i][j] = req_dots[i*w_digit + j];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      rr_nxt    = rr;
      owner_nxt = owner;
      case (state)
         IDLE: if (|req) begin
            state_nxt = OWN;
            grant_nxt = {{(n_req-1){1'b0}}, 1'b1} << winner;
            owner_nxt = winner;
         end
         OWN: if (!owner_req || (hold_cnt == '0 && others_req)) begin
            state_nxt = BLANK;
            grant_nxt = '0;
            rr_nxt    = (owner == OW'(n_req - 1)) ? '0 : owner + OW'(1);
         end
         BLANK: if (tick && blank_cnt == BW'(1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant     <= '0;
         rr        <= '0;
         owner     <= '0;
         tick_cnt  <= '0;
         scan_idx  <= '0;
         hold_cnt  <= '0;
         blank_cnt <= '0;
         digit     <= '0;
         abcdefgh  <= '0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         rr    <= rr_nxt;
         owner <= owner_nxt;

         tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
         if (tick) scan_idx <= (scan_idx == IW'(w_digit - 1)) ? '0 : scan_idx + IW'(1);

         if (state == IDLE && state_nxt == OWN)
            hold_cnt <= HW'(hold_ticks);
         else if (state == OWN && tick && hold_cnt != '0)
            hold_cnt <= hold_cnt - HW'(1);

         // Blank frame length counts ticks seen after entry, not the entry cycle.
         if (state == OWN && state_nxt == BLANK)
            blank_cnt <= BW'(w_digit);
         else if (state == BLANK && tick && blank_cnt != '0)
            blank_cnt <= blank_cnt - BW'(1);

         if (state == OWN) begin
            digit    <= w_digit'(1) << scan_idx;
            abcdefgh <= {hex7(nib_of[owner][scan_idx]), dot_of[owner][scan_idx]};
         end else begin
            digit    <= '0;
            abcdefgh <= '0;
         end
      end
   end
endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench for seg7_display_arbiter with a 4-cycle digit slot and 8-tick hold.
module tb_seg7_display_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req = '0;
   logic [31:0] req_value = '0;
   logic [7:0]  req_dots = '0;
   logic [1:0]  grant;
   logic [7:0]  abcdefgh;
   logic [3:0]  digit;
   logic        busy;

   int total = 0;
   int bad   = 0;

   // Seven-segment glyphs, bit 6 = a .. bit 0 = g.
   logic [6:0] gl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   seg7_display_arbiter #(.w_digit(4), .n_req(2), .digit_period(4), .hold_ticks(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_value(req_value), .req_dots(req_dots),
      .grant(grant), .abcdefgh(abcdefgh), .digit(digit), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Ends on the negedge where reset is released; cyc(n) then lands after posedge n.
   task automatic do_reset(input logic [1:0] r, input logic [31:0] v, input logic [7:0] d);
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      repeat (2) @(negedge clk);
      req_value = v;
      req_dots  = d;
      req       = r;
      rst_n     = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req = 2'(i + 1);
         @(negedge clk);
         total++;
         if ({grant, abcdefgh, digit, busy} !== 15'h0) begin
            bad++;
            $display("FAIL reset_outputs[%0d] got grant=%b seg=%h digit=%b busy=%b exp all zero",
                     i, grant, abcdefgh, digit, busy);
         end
      end
      req   = '0;
      rst_n = 1'b1;
      for (int n = 1; n < 4; n++) begin
         cyc(3);
         total++;
         if (dut.scan_idx !== 2'(n - 1)) begin
            bad++;
            $display("FAIL scan_hold[%0d] got=%0d exp=%0d", n, dut.scan_idx, n - 1);
         end
         cyc(1);
         total++;
         if (dut.scan_idx !== 2'(n)) begin
            bad++;
            $display("FAIL scan_step[%0d] got=%0d exp=%0d", n, dut.scan_idx, n);
         end
      end
   endtask

   task automatic test_single_owner();
      logic [7:0] exp_seg [4] = '{8'h67, 8'hF2, 8'hDA, 8'h60};
      do_reset(2'b01, 32'h0000_1234, 8'h01);
      cyc(1);
      total++;
      if (grant !== 2'b01 || busy !== 1'b1) begin
         bad++;
         $display("FAIL single_grant got grant=%b busy=%b exp grant=01 busy=1", grant, busy);
      end
      cyc(1);
      for (int k = 0; k < 4; k++) begin
         total++;
         if (digit !== 4'(1 << k) || abcdefgh !== exp_seg[k]) begin
            bad++;
            $display("FAIL single_slot[%0d] got digit=%b seg=%h exp digit=%b seg=%h",
                     k, digit, abcdefgh, 4'(1 << k), exp_seg[k]);
         end
         if (k < 3) cyc(4);
      end
      cyc(3);
      req_value = 32'h0000_123F;
      cyc(1);
      total++;
      if (digit !== 4'b0001 || abcdefgh !== 8'h8F) begin
         bad++;
         $display("FAIL live_update got digit=%b seg=%h exp digit=0001 seg=8f", digit, abcdefgh);
      end
   endtask

   task automatic test_glyphs();
      for (int j = 0; j < 4; j++) begin
         do_reset(2'b01, {16'h0, 4'(4*j+3), 4'(4*j+2), 4'(4*j+1), 4'(4*j)}, 8'h00);
         cyc(2);
         for (int k = 0; k < 4; k++) begin
            total++;
            if (abcdefgh !== {gl[4*j+k], 1'b0}) begin
               bad++;
               $display("FAIL glyph[%0h] got=%h exp=%h", 4*j+k, abcdefgh, {gl[4*j+k], 1'b0});
            end
            if (k < 3) cyc(4);
         end
      end
   endtask

   task automatic test_preempt();
      do_reset(2'b11, 32'h5678_1234, 8'h00);
      cyc(1);
      total++;
      if (grant !== 2'b01) begin bad++; $display("FAIL pre_first got=%b exp=01", grant); end
      cyc(31);
      total++;
      if (grant !== 2'b01) begin bad++; $display("FAIL pre_hold got=%b exp=01", grant); end
      cyc(1);
      total++;
      if (grant !== 2'b00 || busy !== 1'b1) begin
         bad++;
         $display("FAIL pre_drop got grant=%b busy=%b exp grant=00 busy=1", grant, busy);
      end
      cyc(7);
      total++;
      if (digit !== 4'b0000 || abcdefgh !== 8'h00) begin
         bad++;
         $display("FAIL pre_blank_dark got digit=%b seg=%h exp 0", digit, abcdefgh);
      end
      cyc(8);
      total++;
      if (grant !== 2'b00) begin bad++; $display("FAIL pre_blank_end got=%b exp=00", grant); end
      cyc(1);
      total++;
      if (grant !== 2'b10) begin bad++; $display("FAIL pre_second got=%b exp=10", grant); end
      cyc(1);
      total++;
      if (digit !== 4'b0001 || abcdefgh !== 8'hFE) begin
         bad++;
         $display("FAIL pre_second_data got digit=%b seg=%h exp digit=0001 seg=fe", digit, abcdefgh);
      end
   endtask

   task automatic test_early_release();
      do_reset(2'b11, 32'h5678_1234, 8'h00);
      cyc(1);
      total++;
      if (grant !== 2'b01) begin bad++; $display("FAIL early_first got=%b exp=01", grant); end
      cyc(7);
      req = 2'b10;
      cyc(1);
      total++;
      if (grant !== 2'b00 || busy !== 1'b1) begin
         bad++;
         $display("FAIL early_drop got grant=%b busy=%b exp grant=00 busy=1", grant, busy);
      end
      cyc(15);
      total++;
      if (grant !== 2'b00 || busy !== 1'b0) begin
         bad++;
         $display("FAIL early_idle got grant=%b busy=%b exp grant=00 busy=0", grant, busy);
      end
      cyc(1);
      total++;
      if (grant !== 2'b10) begin bad++; $display("FAIL early_next got=%b exp=10", grant); end
   endtask

   task automatic test_collision();
      do_reset(2'b01, 32'h5678_1234, 8'h00);
      cyc(5);
      req = 2'b10;
      cyc(1);
      total++;
      if (grant !== 2'b00) begin bad++; $display("FAIL coll_drop got=%b exp=00", grant); end
      cyc(14);
      total++;
      if (grant !== 2'b00 || busy !== 1'b0) begin
         bad++;
         $display("FAIL coll_idle got grant=%b busy=%b exp grant=00 busy=0", grant, busy);
      end
      cyc(1);
      total++;
      if (grant !== 2'b10) begin bad++; $display("FAIL coll_grant1 got=%b exp=10", grant); end
      cyc(1);
      req = 2'b00;
      cyc(1);
      total++;
      if (grant !== 2'b00 || busy !== 1'b1) begin
         bad++;
         $display("FAIL coll_release got grant=%b busy=%b exp grant=00 busy=1", grant, busy);
      end
      req = 2'b11;
      cyc(13);
      total++;
      if (grant !== 2'b00) begin bad++; $display("FAIL coll_wait got=%b exp=00", grant); end
      cyc(1);
      total++;
      if (grant !== 2'b01) begin bad++; $display("FAIL coll_rr_wrap got=%b exp=01", grant); end
   endtask

   task automatic test_reset_mid_own();
      do_reset(2'b01, 32'h0000_1234, 8'h01);
      cyc(10);
      total++;
      if (digit !== 4'b0100 || abcdefgh !== 8'hDA) begin
         bad++;
         $display("FAIL mid_slot2 got digit=%b seg=%h exp digit=0100 seg=da", digit, abcdefgh);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({grant, abcdefgh, digit, busy} !== 15'h0) begin
         bad++;
         $display("FAIL mid_async got grant=%b seg=%h digit=%b busy=%b exp all zero",
                  grant, abcdefgh, digit, busy);
      end
      @(negedge clk);
      req   = 2'b10;
      rst_n = 1'b1;
      cyc(1);
      total++;
      if (grant !== 2'b10) begin bad++; $display("FAIL mid_regrant got=%b exp=10", grant); end
   endtask

   initial begin
      test_reset();
      test_single_owner();
      test_glyphs();
      test_preempt();
      test_early_release();
      test_collision();
      test_reset_mid_own();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
